// File: rtl/mux_scan_nx1_if.sv
// Channel bank / consumer bundle for mux_scan_nx1.
// master = the side driving channel data, selection and ready;
// slave  = the mux itself.
interface mux_scan_nx1_if #(
  parameter int NCH   = 8,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(NCH)
);
  logic [NCH*WIDTH-1:0] din;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [NCH-1:0]       ch_en;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;
  logic                 scan_wrap;

  modport master (
    output din, mode, sel, ch_en, out_ready,
    input  out_data, out_ch, out_valid, scan_wrap
  );

  modport slave (
    input  din, mode, sel, ch_en, out_ready,
    output out_data, out_ch, out_valid, scan_wrap
  );
endinterface

// File: rtl/mux_scan_nx1.sv
// N-channel, W-bit registered mux with manual select and round-robin
// auto-scan over enabled channels, output held behind valid/ready.
module mux_scan_nx1 #(
  parameter int NCH   = 8,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_scan_nx1_if.slave bus
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q,   out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic             wrap_q,     wrap_d;
  logic [SELW-1:0]  ptr_q,      ptr_d;

  logic             load;
  logic [NCH-1:0]   rot;
  logic             scan_found;
  int unsigned      scan_off;
  int unsigned      scan_sum;
  int unsigned      scan_c;
  logic             scan_wrapped;
  logic [SELW-1:0]  scan_ptr_nxt;
  logic [WIDTH-1:0] scan_data;
  logic             man_ok;
  logic [WIDTH-1:0] man_data;

  assign load = !out_valid_q || bus.out_ready;

  // Wrap-around priority search from ptr: rotate the enable mask so the
  // search starts at bit 0, then map the offset back to a channel index.
  always_comb begin
    rot          = NCH'({bus.ch_en, bus.ch_en} >> ptr_q);
    scan_found   = 1'b0;
    scan_off     = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!scan_found && rot[i]) begin
        scan_found = 1'b1;
        scan_off   = i;
      end
    end
    scan_sum     = 32'(ptr_q) + scan_off;
    scan_c       = (scan_sum >= 32'(NCH)) ? scan_sum - 32'(NCH) : scan_sum;
    scan_wrapped = scan_found &&
                   ((scan_c == 32'(NCH - 1)) || (scan_sum >= 32'(NCH)));
    scan_ptr_nxt = (scan_c == 32'(NCH - 1)) ? '0 : SELW'(scan_c + 1);
    scan_data    = '0;
    man_ok       = 1'b0;
    man_data     = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (SELW'(k) == SELW'(scan_c))
        scan_data = bus.din[k*WIDTH +: WIDTH];
      if (SELW'(k) == bus.sel) begin
        man_ok   = bus.ch_en[k];
        man_data = bus.din[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next output word: hold on stall, otherwise manual pick or scan result.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    wrap_d      = 1'b0;
    if (load) begin
      if (!bus.mode) begin
        if (man_ok) begin
          out_data_d  = man_data;
          out_ch_d    = bus.sel;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (scan_found) begin
        out_data_d  = scan_data;
        out_ch_d    = SELW'(scan_c);
        out_valid_d = 1'b1;
        ptr_d       = scan_ptr_nxt;
        wrap_d      = scan_wrapped;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Output and scan-pointer registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.scan_wrap = wrap_q;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Bench for mux_scan_nx1: an 8x8 and a 6x12 instance share clock and
// reset; both are compared every cycle against a behavioural model,
// plus directed checks against fixed expected values.
module tb_mux_scan_nx1;

  logic clk;
  logic rst_n;

  mux_scan_nx1_if #(.NCH(8), .WIDTH(8))  ifa ();
  mux_scan_nx1_if #(.NCH(6), .WIDTH(12)) ifb ();

  mux_scan_nx1 #(.NCH(8), .WIDTH(8))  u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  mux_scan_nx1 #(.NCH(6), .WIDTH(12)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state per instance (0 = 8x8, 1 = 6x12).
  logic [63:0] m_data [2];
  logic [63:0] m_ch   [2];
  logic        m_valid[2];
  logic        m_wrap [2];
  int          m_ptr  [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_data[d] = '0; m_ch[d] = '0; m_valid[d] = 1'b0; m_wrap[d] = 1'b0; m_ptr[d] = 0;
    end
  endtask

  // One load decision, straight from the behavioural rules.
  task automatic model_step(input int d, input int n, input int w, input logic [767:0] din,
                            input logic mode, input int sel, input logic [63:0] en,
                            input logic ready);
    logic [767:0] t;
    bit found;
    int c;
    m_wrap[d] = 1'b0;
    if (m_valid[d] && !ready) return;
    if (!mode) begin
      if (sel < n && en[sel]) begin
        t = din >> (sel * w);
        m_data[d]  = t[63:0] & ((64'd1 << w) - 64'd1);
        m_ch[d]    = 64'(sel);
        m_valid[d] = 1'b1;
      end else begin
        m_valid[d] = 1'b0;
      end
    end else begin
      found = 0;
      for (int i = 0; i < n; i++) begin
        c = (m_ptr[d] + i) % n;
        if (!found && en[c]) begin
          found = 1;
          t = din >> (c * w);
          m_data[d]  = t[63:0] & ((64'd1 << w) - 64'd1);
          m_ch[d]    = 64'(c);
          m_valid[d] = 1'b1;
          m_wrap[d]  = (c == n - 1) || (c < m_ptr[d]);
          m_ptr[d]   = (c + 1) % n;
        end
      end
      if (!found) m_valid[d] = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("a_data",  64'(ifa.out_data),  m_data[0]);
    check("a_ch",    64'(ifa.out_ch),    m_ch[0]);
    check("a_valid", 64'(ifa.out_valid), 64'(m_valid[0]));
    check("a_wrap",  64'(ifa.scan_wrap), 64'(m_wrap[0]));
    check("b_data",  64'(ifb.out_data),  m_data[1]);
    check("b_ch",    64'(ifb.out_ch),    m_ch[1]);
    check("b_valid", 64'(ifb.out_valid), 64'(m_valid[1]));
    check("b_wrap",  64'(ifb.scan_wrap), 64'(m_wrap[1]));
  endtask

  task automatic tick();
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step(0, 8, 8,  768'(ifa.din), ifa.mode, int'(ifa.sel), 64'(ifa.ch_en), ifa.out_ready);
      model_step(1, 6, 12, 768'(ifb.din), ifb.mode, int'(ifb.sel), 64'(ifb.ch_en), ifb.out_ready);
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  int exp_ch  [6] = '{0, 2, 5, 7, 0, 2};
  int exp_wrap[6] = '{0, 0, 0, 1, 0, 0};
  logic [7:0] ch2_val;
  int r;

  initial begin
    rst_n = 1'b0;
    ifa.din = '0; ifa.mode = 1'b0; ifa.sel = '0; ifa.ch_en = '0; ifa.out_ready = 1'b0;
    ifb.din = '0; ifb.mode = 1'b0; ifb.sel = '0; ifb.ch_en = '0; ifb.out_ready = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Manual select on A; out-of-range select on B.
    ifa.din = 64'h00A5_0000_005A_3C00;
    ifa.ch_en = 8'hFF; ifa.out_ready = 1'b1; ifa.sel = 3'd1;
    ifb.din = 72'h123_456_789_ABC_DEF_321;
    ifb.ch_en = 6'h3F; ifb.out_ready = 1'b1; ifb.sel = 3'd7;
    tick();
    check("t1_data1", 64'(ifa.out_data), 64'h3C);
    check("t1_ch1",   64'(ifa.out_ch),   64'd1);
    check("t1_valid", 64'(ifa.out_valid), 64'd1);
    check("t5_sel7",  64'(ifb.out_valid), 64'd0);
    ifa.sel = 3'd6;
    tick();
    check("t1_data6", 64'(ifa.out_data), 64'hA5);
    check("t1_ch6",   64'(ifa.out_ch),   64'd6);

    // Scan order and wrap on sparse mask.
    ifa.ch_en = 8'b1010_0101; ifa.mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t2_ch",   64'(ifa.out_ch),    64'(exp_ch[i]));
      check("t2_wrap", 64'(ifa.scan_wrap), 64'(exp_wrap[i]));
    end

    // Backpressure: hold ch2 word while inputs move.
    ch2_val = ifa.din[23:16];
    ifa.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifa.din[23:16] = 8'($urandom);
      ifa.din[47:40] = 8'($urandom);
      tick();
      check("t3_hold_ch",   64'(ifa.out_ch),   64'd2);
      check("t3_hold_data", 64'(ifa.out_data), 64'(ch2_val));
    end
    ifa.out_ready = 1'b1;
    tick();
    check("t3_next_ch",   64'(ifa.out_ch),   64'd5);
    check("t3_next_data", 64'(ifa.out_data), 64'(ifa.din[47:40]));

    // Nothing enabled, re-enable ch3, disabled manual select.
    ifa.ch_en = 8'h00;
    tick();
    check("t4_none_scan", 64'(ifa.out_valid), 64'd0);
    ifa.mode = 1'b0;
    tick();
    check("t4_none_man", 64'(ifa.out_valid), 64'd0);
    ifa.mode = 1'b1; ifa.ch_en = 8'h08;
    tick();
    check("t4_ch3", 64'(ifa.out_ch), 64'd3);
    check("t4_ch3_wrap", 64'(ifa.scan_wrap), 64'd1);
    ifa.mode = 1'b0; ifa.sel = 3'd4; ifa.ch_en = 8'hEF;
    tick();
    check("t4_dis4", 64'(ifa.out_valid), 64'd0);

    // Non-power-of-2 scan on B.
    ifb.mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t5_ch",   64'(ifb.out_ch),    64'(i % 6));
      check("t5_wrap", 64'(ifb.scan_wrap), 64'(i == 5));
    end

    // Random traffic on both instances.
    for (int cyc = 0; cyc < 400; cyc++) begin
      ifa.din  = {$urandom, $urandom};
      ifb.din  = 72'({$urandom, $urandom, $urandom});
      ifa.mode = 1'($urandom_range(0, 1));
      ifb.mode = 1'($urandom_range(0, 1));
      ifa.sel  = 3'($urandom_range(0, 7));
      ifb.sel  = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 7);
      ifa.ch_en = (r == 0) ? 8'h00 : (r == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      r = $urandom_range(0, 7);
      ifb.ch_en = (r == 0) ? 6'h00 : (r == 1) ? 6'(1 << $urandom_range(0, 5)) : 6'($urandom);
      ifa.out_ready = ($urandom_range(0, 9) < 7);
      ifb.out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end

    // Asynchronous reset during a stall with valid data.
    ifa.mode = 1'b1; ifa.ch_en = 8'hFF; ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    tick();
    check("t6_pre_valid", 64'(ifa.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("t6_rst_data", 64'(ifa.out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ifa.out_ready = 1'b1;
    tick();
    check("t6_restart_ch",    64'(ifa.out_ch),    64'd0);
    check("t6_restart_valid", 64'(ifa.out_valid), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_nx1.md
Name: mux_scan_nx1

Overview:
Parametrised N-channel, W-bit registered multiplexer. It supersedes the fixed 8:1 single-bit combinational mux.
- Adds a manual-select mode and an auto-scan mode that round-robins over enabled channels.
- Output is registered behind a valid/ready handshake.
- Sits between a bank of parallel sources (sensor or register taps) and a single serial consumer.

Parameters:
NCH, 8, number of input channels (2..64, need not be a power of 2)
WIDTH, 8, data bits per channel
SELW, $clog2(NCH), select/channel-index width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
din  input  NCH*WIDTH  packed channel data; channel k at bits [k*WIDTH +: WIDTH]
mode  input  1  0 = manual select, 1 = auto-scan
sel  input  SELW  manual channel index
ch_en  input  NCH  per-channel enable mask; bit k enables channel k
out_data  output  WIDTH  registered selected data
out_ch  output  SELW  index of channel held in out_data
out_valid  output  1  out_data/out_ch valid
out_ready  input  1  consumer accepts when out_valid && out_ready
scan_wrap  output  1  one-cycle pulse: scan pass completed

Behaviour:
- Reset: rst_n low forces all registers immediately, independent of clk:
  - out_data = 0, out_ch = 0, out_valid = 0, scan_wrap = 0, scan pointer ptr = 0.
  - Release is synchronous-safe: the first load occurs on the first rising edge with rst_n high.
- Load condition: load = !out_valid || out_ready.
  - When load = 0 (stall), out_data, out_ch, out_valid and ptr hold. din, sel, ch_en and mode changes are ignored. scan_wrap = 0.
- Sampling: mode, sel, ch_en and din are sampled only on a load edge. Latency is 1 clock from sampled inputs to out_*.
- Manual mode (mode = 0), on load:
  - If sel < NCH and ch_en[sel] = 1: out_data = din[sel], out_ch = sel, out_valid = 1.
  - Otherwise (out-of-range sel or disabled channel): out_valid = 0; out_data and out_ch hold.
  - ptr is not modified; scan_wrap = 0.
- Auto-scan mode (mode = 1), on load:
  - Search for the first channel c with ch_en[c] = 1, in order ptr, ptr+1, …, NCH-1, 0, …, ptr-1 (inclusive wrap-around priority search).
  - Found: out_data = din[c], out_ch = c, out_valid = 1, ptr = (c == NCH-1) ? 0 : c+1.
  - scan_wrap = 1 for that cycle if c == NCH-1 or c < ptr_old (search wrapped); else 0.
  - None enabled: out_valid = 0, ptr holds, scan_wrap = 0.
- Pointer range: ptr never exceeds NCH-1, including when NCH is not a power of 2.
- Mode change: takes effect at the next load. ptr is preserved across manual periods, so scanning resumes where it stopped.
- Continuous ready: with out_ready held high, one new word loads per clock (full throughput).
- Single enabled channel k in scan mode: out_ch = k every load. scan_wrap pulses every load if k == NCH-1 or k < ptr_old.
- Handshake integrity: out_valid never drops without a transfer unless the re-load finds nothing valid. A valid word is never overwritten while out_ready = 0.

Test Plan:
1. Reset then manual: NCH = 8, WIDTH = 8; din ch1 = 8'h3C, ch6 = 8'hA5, ch_en = 8'hFF, out_ready = 1; sel = 1 then sel = 6 -> one cycle after each, out_data = 3C/out_ch = 1, then A5/6, out_valid = 1.
2. Scan order and wrap: ch_en = 8'b1010_0101, mode = 1, out_ready = 1 from reset -> out_ch sequence 0, 2, 5, 7, 0, 2; scan_wrap high only with out_ch = 7.
3. Backpressure: scanning with out_valid = 1, out_ch = 2; drop out_ready for 4 cycles while changing din ch2 and ch5 -> out_data/out_ch frozen at ch2 value. Raise ready -> next out_ch = 5 with the current din ch5.
4. All disabled and invalid select:
   - ch_en = 0 in either mode -> out_valid = 0, ptr unchanged.
   - Re-enable ch3 -> next load out_ch = 3.
   - Manual sel = 4 with ch_en[4] = 0 -> out_valid = 0.
5. Non-power-of-2: NCH = 6, WIDTH = 12; manual sel = 7 -> out_valid = 0. Scan with all enabled -> out_ch 0..5 then 0, scan_wrap at 5.
6. Async reset mid-operation: assert rst_n low between clock edges during a stall with out_valid = 1 -> all outputs 0 immediately, without a clock edge. After release, scan restarts at ch0.
